m10k_burst_writer: RTL and testbench

- Parametrised M10K row writer that streams a latched matrix of up to ROWS row-vectors (N words of DATA_LEN bits each) into an M10K port.
- Writes start at a runtime base address and advance by a fixed stride.
- Supports memory backpressure, a runtime row count, abort, and address-wrap flagging.
- Sits between the PE array output collector and the M10K result buffer; it replaces fixed 4-row, fixed-offset write sequencers.

---
 rtl/m10k_burst_writer.sv | 203 ++++++++++++++++++++
 tb/tb_m10k_burst_writer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m10k_burst_writer.sv
// m10k_burst_writer
// Streams a latched matrix of up to ROWS row vectors into an M10K write port.
// Rows go out one per accepted write, starting at a runtime base address and
// advancing by STRIDE. Supports memory backpressure, a runtime row count,
// abort, and a sticky per-burst address-wrap flag. All outputs are registered.
module m10k_burst_writer #(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int ROWS         = 4,
    parameter int ADDRESS_SIZE = 4,
    parameter int STRIDE       = 1,
    localparam int CNT_W       = $clog2(ROWS + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_write_start,
    input  logic [ADDRESS_SIZE-1:0]      i_base_addr,
    input  logic [CNT_W-1:0]             i_num_rows,
    input  logic [DATA_LEN*N*ROWS-1:0]   i_in_mat,
    input  logic                         i_mem_ready,
    input  logic                         i_abort,
    output logic [ADDRESS_SIZE-1:0]      o_write_addr,
    output logic [DATA_LEN*N-1:0]        o_write_data,
    output logic                         o_write_en,
    output logic [CNT_W-1:0]             o_row_idx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_wrapped,
    output logic [1:0]                   o_state
);

    localparam int ROW_W = DATA_LEN * N;
    localparam int MAT_W = ROW_W * ROWS;
    localparam logic [ADDRESS_SIZE:0] STRIDE_EXT = (ADDRESS_SIZE + 1)'(STRIDE);
    localparam logic [CNT_W-1:0]      ROWS_CNT   = CNT_W'(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                  state_q,   state_d;
    logic [MAT_W-1:0]        mat_q,     mat_d;
    logic [CNT_W-1:0]        n_q,       n_d;
    logic [ADDRESS_SIZE-1:0] addr_q,    addr_d;
    logic [ROW_W-1:0]        data_q,    data_d;
    logic                    en_q,      en_d;
    logic [CNT_W-1:0]        row_idx_q, row_idx_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic                    wrapped_q, wrapped_d;

    logic [CNT_W-1:0]        n_eff_s;
    logic [CNT_W-1:0]        row_next_s;
    logic [ADDRESS_SIZE:0]   addr_sum_s;
    logic [ROW_W-1:0]        row_next_data_s;
    logic                    accept_s;
    logic                    last_row_s;

    // Requested row count saturates at the matrix capacity.
    assign n_eff_s    = (i_num_rows > ROWS_CNT) ? ROWS_CNT : i_num_rows;
    assign accept_s   = en_q & i_mem_ready;
    assign last_row_s = (row_idx_q == (n_q - CNT_W'(1)));
    assign row_next_s = row_idx_q + CNT_W'(1);
    // The extra top bit is the carry that flags an address wrap.
    assign addr_sum_s = {1'b0, addr_q} + STRIDE_EXT;

    // One-hot OR mux selecting the row that follows the one being presented.
    always_comb begin
        row_next_data_s = {ROW_W{1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            row_next_data_s = row_next_data_s |
                ((row_next_s == CNT_W'(r)) ? mat_q[r*ROW_W +: ROW_W] : {ROW_W{1'b0}});
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d   = state_q;
        mat_d     = mat_q;
        n_d       = n_q;
        addr_d    = addr_q;
        data_d    = data_q;
        en_d      = en_q;
        row_idx_d = row_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wrapped_d = wrapped_q;

        case (state_q)
            ST_IDLE: begin
                en_d      = 1'b0;
                busy_d    = 1'b0;
                addr_d    = '0;
                data_d    = '0;
                row_idx_d = '0;
                if (i_write_start) begin
                    mat_d     = i_in_mat;
                    n_d       = n_eff_s;
                    wrapped_d = 1'b0;
                    if (n_eff_s == CNT_W'(0)) begin
                        // Empty burst completes without touching memory.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = i_base_addr;
                        data_d  = i_in_mat[ROW_W-1:0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (i_abort) begin
                    // A row accepted this cycle still counts; nothing more is presented.
                    state_d   = ST_IDLE;
                    en_d      = 1'b0;
                    busy_d    = 1'b0;
                    addr_d    = '0;
                    data_d    = '0;
                    row_idx_d = '0;
                end else if (accept_s && last_row_s) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    en_d      = 1'b0;
                    busy_d    = 1'b0;
                    addr_d    = '0;
                    data_d    = '0;
                    row_idx_d = '0;
                end else if (accept_s) begin
                    row_idx_d = row_next_s;
                    addr_d    = addr_sum_s[ADDRESS_SIZE-1:0];
                    data_d    = row_next_data_s;
                    wrapped_d = wrapped_q | addr_sum_s[ADDRESS_SIZE];
                end else begin
                    // Backpressure: hold the presented row unchanged.
                    state_d = ST_WRITE;
                end
            end

            ST_DONE: begin
                state_d   = ST_IDLE;
                en_d      = 1'b0;
                busy_d    = 1'b0;
                addr_d    = '0;
                data_d    = '0;
                row_idx_d = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                en_d      = 1'b0;
                busy_d    = 1'b0;
                addr_d    = '0;
                data_d    = '0;
                row_idx_d = '0;
                wrapped_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            mat_q     <= '0;
            n_q       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mat_q     <= mat_d;
            n_q       <= n_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            en_q      <= en_d;
            row_idx_q <= row_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign o_write_addr = addr_q;
    assign o_write_data = data_q;
    assign o_write_en   = en_q;
    assign o_row_idx    = row_idx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_wrapped    = wrapped_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_m10k_burst_writer.sv
// Self-checking bench for m10k_burst_writer. Expected writes are pushed to a
// scoreboard queue when a burst is started and popped as the DUT writes.
module tb_m10k_burst_writer;

    localparam int DATA_LEN     = 32;
    localparam int N            = 8;
    localparam int ROWS         = 4;
    localparam int ADDRESS_SIZE = 4;
    localparam int STRIDE       = 1;
    localparam int CNT_W        = $clog2(ROWS + 1);
    localparam int ROW_W        = DATA_LEN * N;
    localparam int MAT_W        = ROW_W * ROWS;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDRESS_SIZE-1:0] base;
    logic [CNT_W-1:0]        num_rows;
    logic [MAT_W-1:0]        in_mat;
    logic                    ready;
    logic                    abort;
    logic [ADDRESS_SIZE-1:0] o_write_addr;
    logic [ROW_W-1:0]        o_write_data;
    logic                    o_write_en;
    logic [CNT_W-1:0]        o_row_idx;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_wrapped;
    logic [1:0]              o_state;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] addr;
        logic [CNT_W-1:0]        idx;
        logic                    wrapped;
        logic [ROW_W-1:0]        data;
    } exp_t;

    typedef struct packed {
        logic                    en;
        logic                    done;
        logic                    busy;
        logic                    wrapped;
        logic [1:0]              state;
        logic [CNT_W-1:0]        idx;
        logic [ADDRESS_SIZE-1:0] addr;
        logic [ROW_W-1:0]        data;
    } snap_t;

    exp_t  exp_q[$];
    snap_t tr[$];
    bit    rdy[$];
    int    errors = 0;
    int    checks = 0;

    m10k_burst_writer #(
        .DATA_LEN(DATA_LEN), .N(N), .ROWS(ROWS),
        .ADDRESS_SIZE(ADDRESS_SIZE), .STRIDE(STRIDE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_write_start(start), .i_base_addr(base),
        .i_num_rows(num_rows), .i_in_mat(in_mat), .i_mem_ready(ready), .i_abort(abort),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data), .o_write_en(o_write_en),
        .o_row_idx(o_row_idx), .o_busy(o_busy), .o_done(o_done), .o_wrapped(o_wrapped),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < MAT_W / 32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    // Reference model: the rows a burst should write, in order.
    task automatic push_expected(input logic [ADDRESS_SIZE-1:0] b, input int n, input logic [MAT_W-1:0] m);
        exp_t e;
        int   bi;
        bi = int'(b);
        for (int r = 0; r < n; r++) begin
            e.addr    = ADDRESS_SIZE'((bi + r * STRIDE) % (1 << ADDRESS_SIZE));
            e.idx     = CNT_W'(r);
            e.wrapped = ((bi + r * STRIDE) > ((1 << ADDRESS_SIZE) - 1));
            e.data    = m[r*ROW_W +: ROW_W];
            exp_q.push_back(e);
        end
    endtask

    // Pulse start for one cycle, then scramble the inputs the DUT must have latched.
    task automatic start_burst(input logic [ADDRESS_SIZE-1:0] b, input logic [CNT_W-1:0] n, input logic [MAT_W-1:0] m);
        base = b; num_rows = n; in_mat = m; start = 1'b1;
        tick;
        start    = 1'b0;
        base     = ADDRESS_SIZE'($urandom);
        num_rows = CNT_W'($urandom);
        in_mat   = rand_mat();
    endtask

    // Record outputs for ncyc cycles; ready low in [lo_a,lo_b], abort in abort_cyc.
    task automatic capture(input int ncyc, input int lo_a, input int lo_b, input int abort_cyc);
        snap_t s;
        tr.delete();
        rdy.delete();
        for (int c = 1; c <= ncyc; c++) begin
            ready = !(c >= lo_a && c <= lo_b);
            abort = (c == abort_cyc);
            s = {o_write_en, o_done, o_busy, o_wrapped, o_state, o_row_idx, o_write_addr, o_write_data};
            tr.push_back(s);
            rdy.push_back(ready);
            tick;
        end
        ready = 1'b1;
        abort = 1'b0;
    endtask

    function automatic int first_done();
        for (int i = 0; i < tr.size(); i++) if (tr[i].done) return i + 1;
        return -1;
    endfunction

    function automatic int count_done();
        int k = 0;
        for (int i = 0; i < tr.size(); i++) if (tr[i].done) k++;
        return k;
    endfunction

    function automatic int count_en();
        int k = 0;
        for (int i = 0; i < tr.size(); i++) if (tr[i].en) k++;
        return k;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; base = 4'd9; num_rows = 3'd3; in_mat = rand_mat();
        tick;
        tick;
        checks++;
        if ({o_write_addr, o_write_data, o_write_en, o_row_idx, o_busy, o_done, o_wrapped, o_state} !== '0)
            begin errors++; $display("FAIL reset_outputs: addr=%0d en=%b idx=%0d busy=%b done=%b wrap=%b state=%0d, expected all zero", o_write_addr, o_write_en, o_row_idx, o_busy, o_done, o_wrapped, o_state); end
        rst = 1'b0; start = 1'b0;
        tick;
        checks++;
        if (o_state !== 2'd0 || o_write_en !== 1'b0)
            begin errors++; $display("FAIL reset_idle: state=%0d en=%b, expected state=0 en=0", o_state, o_write_en); end
    endtask

    task automatic test_basic;
        logic [MAT_W-1:0] m;
        logic [3:0]       nib;
        exp_t             e, got;
        int               nw;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            nib = 4'hA + 4'(r);
            for (int w = 0; w < N; w++) m[r*ROW_W + w*DATA_LEN +: DATA_LEN] = {8{nib}};
        end
        exp_q.delete();
        push_expected(4'd12, 4, m);
        start_burst(4'd12, 3'd4, m);
        capture(10, 0, -1, 0);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL basic_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL basic_write: got %h expected %h", got, e); end
                end
                checks++;
                if (i != nw) begin errors++; $display("FAIL basic_cycle: write %0d at cycle %0d, expected cycle %0d", nw, i + 1, nw + 1); end
                nw++;
            end
        end
        checks++;
        if (nw != 4) begin errors++; $display("FAIL basic_count: writes=%0d expected 4", nw); end
        checks++;
        if (first_done() != 5) begin errors++; $display("FAIL basic_done_cycle: done at %0d expected 5", first_done()); end
        checks++;
        if (count_done() != 1) begin errors++; $display("FAIL basic_done_count: %0d expected 1", count_done()); end
        checks++;
        if (tr[0].busy !== 1'b1 || tr[0].state !== 2'd1) begin errors++; $display("FAIL basic_busy: busy=%b state=%0d expected 1/1", tr[0].busy, tr[0].state); end
        checks++;
        if ({tr[9].addr, tr[9].data, tr[9].wrapped} !== '0) begin errors++; $display("FAIL basic_idle_out: addr=%0d wrap=%b expected 0/0", tr[9].addr, tr[9].wrapped); end
    endtask

    task automatic test_backpressure;
        logic [MAT_W-1:0] m;
        exp_t             e, got, e1;
        int               nw;
        int               acc_cyc[3] = '{1, 4, 5};
        m = rand_mat();
        exp_q.delete();
        push_expected(4'd5, 3, m);
        e1 = exp_q[1];
        start_burst(4'd5, 3'd3, m);
        capture(10, 2, 3, 0);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0 || nw > 2) begin errors++; $display("FAIL bp_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL bp_write: got %h expected %h", got, e); end
                    checks++;
                    if (i + 1 != acc_cyc[nw]) begin errors++; $display("FAIL bp_cycle: write %0d at cycle %0d expected %0d", nw, i + 1, acc_cyc[nw]); end
                end
                nw++;
            end
        end
        for (int c = 2; c <= 4; c++) begin
            got = {tr[c-1].addr, tr[c-1].idx, tr[c-1].wrapped, tr[c-1].data};
            checks++;
            if (tr[c-1].en !== 1'b1 || got !== e1) begin errors++; $display("FAIL bp_hold: cycle %0d en=%b got %h expected en=1 %h", c, tr[c-1].en, got, e1); end
        end
        checks++;
        if (nw != 3) begin errors++; $display("FAIL bp_count: writes=%0d expected 3", nw); end
        checks++;
        if (first_done() != 6) begin errors++; $display("FAIL bp_done_cycle: done at %0d expected 6", first_done()); end
    endtask

    task automatic test_wrap;
        logic [MAT_W-1:0] m;
        exp_t             e, got;
        int               nw;
        m = rand_mat();
        exp_q.delete();
        push_expected(4'd14, 4, m);
        start_burst(4'd14, 3'd4, m);
        capture(8, 0, -1, 0);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL wrap_write: got %h expected %h", got, e); end
                end
                nw++;
            end
        end
        checks++;
        if (nw != 4) begin errors++; $display("FAIL wrap_count: writes=%0d expected 4", nw); end
        checks++;
        if (tr[4].done !== 1'b1 || tr[4].wrapped !== 1'b1) begin errors++; $display("FAIL wrap_done: done=%b wrapped=%b expected 1/1", tr[4].done, tr[4].wrapped); end
        checks++;
        if (tr[7].wrapped !== 1'b1) begin errors++; $display("FAIL wrap_sticky: wrapped=%b expected 1", tr[7].wrapped); end
    endtask

    task automatic test_row_limits;
        logic [MAT_W-1:0] m;
        exp_t             e, got;
        int               nw;
        m = rand_mat();
        exp_q.delete();
        start_burst(4'd3, 3'd0, m);
        capture(4, 0, -1, 0);
        checks++;
        if (count_en() != 0) begin errors++; $display("FAIL zero_rows_en: en cycles=%0d expected 0", count_en()); end
        checks++;
        if (first_done() != 1 || tr[0].state !== 2'd2) begin errors++; $display("FAIL zero_rows_done: done at %0d state=%0d expected 1/2", first_done(), tr[0].state); end
        checks++;
        if (tr[0].wrapped !== 1'b0 || tr[1].state !== 2'd0) begin errors++; $display("FAIL zero_rows_clear: wrapped=%b next state=%0d expected 0/0", tr[0].wrapped, tr[1].state); end
        m = rand_mat();
        push_expected(4'd2, 4, m);
        start_burst(4'd2, 3'd7, m);
        capture(8, 0, -1, 0);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL clamp_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL clamp_write: got %h expected %h", got, e); end
                end
                nw++;
            end
        end
        checks++;
        if (nw != 4) begin errors++; $display("FAIL clamp_count: writes=%0d expected 4", nw); end
        checks++;
        if (first_done() != 5) begin errors++; $display("FAIL clamp_done: done at %0d expected 5", first_done()); end
    endtask

    task automatic test_abort;
        logic [MAT_W-1:0] m;
        exp_t             e, got;
        int               nw;
        m = rand_mat();
        exp_q.delete();
        push_expected(4'd8, 2, m);
        start_burst(4'd8, 3'd4, m);
        capture(8, 0, -1, 2);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL abort_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL abort_write: got %h expected %h", got, e); end
                end
                nw++;
            end
        end
        checks++;
        if (nw != 2) begin errors++; $display("FAIL abort_count: writes=%0d expected 2", nw); end
        checks++;
        if (tr[2].en !== 1'b0 || tr[2].state !== 2'd0 || tr[2].busy !== 1'b0) begin errors++; $display("FAIL abort_idle: en=%b state=%0d busy=%b expected 0/0/0", tr[2].en, tr[2].state, tr[2].busy); end
        checks++;
        if (count_done() != 0) begin errors++; $display("FAIL abort_no_done: done pulses=%0d expected 0", count_done()); end
        m = rand_mat();
        push_expected(4'd9, 2, m);
        start_burst(4'd9, 3'd2, m);
        capture(6, 0, -1, 0);
        nw = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].en && rdy[i]) begin
                got = {tr[i].addr, tr[i].idx, tr[i].wrapped, tr[i].data};
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL restart_write: unexpected write at cycle %0d, expected none", i + 1); end
                else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL restart_write: got %h expected %h", got, e); end
                end
                nw++;
            end
        end
        checks++;
        if (nw != 2 || first_done() != 3) begin errors++; $display("FAIL restart_done: writes=%0d done at %0d expected 2/3", nw, first_done()); end
    endtask

    task automatic test_reset_mid;
        exp_q.delete();
        ready = 1'b1;
        start_burst(4'd4, 3'd4, rand_mat());
        tick;
        tick;
        checks++;
        if (o_write_en !== 1'b1 || o_row_idx !== 3'd2 || o_write_addr !== 4'd6) begin errors++; $display("FAIL rstmid_row2: en=%b idx=%0d addr=%0d expected 1/2/6", o_write_en, o_row_idx, o_write_addr); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({o_write_addr, o_write_data, o_write_en, o_row_idx, o_busy, o_done, o_wrapped, o_state} !== '0)
            begin errors++; $display("FAIL rstmid_outputs: addr=%0d en=%b idx=%0d busy=%b done=%b state=%0d expected all zero", o_write_addr, o_write_en, o_row_idx, o_busy, o_done, o_state); end
        capture(4, 0, -1, 0);
        checks++;
        if (count_done() != 0 || count_en() != 0) begin errors++; $display("FAIL rstmid_quiet: done=%0d en=%0d expected 0/0", count_done(), count_en()); end
    endtask

    task automatic test_start_in_done;
        logic [MAT_W-1:0] m;
        exp_t             e, got;
        m = rand_mat();
        exp_q.delete();
        push_expected(4'd0, 1, m);
        start_burst(4'd0, 3'd1, m);
        got = {o_write_addr, o_row_idx, o_wrapped, o_write_data};
        e = exp_q.pop_front();
        checks++;
        if (o_write_en !== 1'b1 || got !== e) begin errors++; $display("FAIL sid_write: en=%b got %h expected en=1 %h", o_write_en, got, e); end
        tick;
        checks++;
        if (o_state !== 2'd2 || o_done !== 1'b1) begin errors++; $display("FAIL sid_done: state=%0d done=%b expected 2/1", o_state, o_done); end
        start = 1'b1; base = 4'd7; num_rows = 3'd2; in_mat = rand_mat();
        tick;
        start = 1'b0;
        checks++;
        if (o_state !== 2'd0 || o_write_en !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL sid_ignored: state=%0d en=%b done=%b expected 0/0/0", o_state, o_write_en, o_done); end
        tick;
        checks++;
        if (o_state !== 2'd0 || o_write_en !== 1'b0) begin errors++; $display("FAIL sid_stay_idle: state=%0d en=%b expected 0/0", o_state, o_write_en); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; num_rows = '0; in_mat = '0; ready = 1'b1; abort = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_row_limits;
        test_abort;
        test_reset_mid;
        test_start_in_done;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
